// File: rtl/parallax_pkg.sv
// Shared stereo-geometry constants and state type for the depth-to-disparity path.
// The DEPTH_TO_DISP_ROUND_EN macro (used by the top) selects a rounded divide.
package parallax_pkg;

  // Integer units chosen so that focal * baseline * pixels / sensor = 495 pixel-inches.
  localparam int RESOLUTION_WIDTH  = 1280;
  localparam int SENSOR_WIDTH      = 256;
  localparam int FOCAL_LENGTH      = 11;
  localparam int BASELINE_DISTANCE = 9;
  localparam int PARALLAX_SCALE    =
    (FOCAL_LENGTH * BASELINE_DISTANCE * RESOLUTION_WIDTH) / SENSOR_WIDTH;

  localparam int X_W     = 12;
  localparam int DIV_W   = 16;
  localparam int DEPTH_W = 8;

  localparam logic [DEPTH_W-1:0] DEPTH_INF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } d2d_state_t;

endpackage

// File: rtl/depth_to_disparity_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first step is taken on the
// start edge itself, so the quotient is ready DIV_W-1 edges later with done pulsed.
module seq_divider #(
  parameter int DIV_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W) + 1;

  logic [DVS_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DVS_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W-1:0] src_rem;
  logic [DIV_W-1:0] src_quo;
  logic [DVS_W-1:0] src_div;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;
  logic [DVS_W-1:0] nxt_rem;
  logic [DIV_W-1:0] nxt_quo;

  // quo shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    src_rem = start ? '0 : rem;
    src_quo = start ? dividend : quo;
    src_div = start ? divisor : div_q;
    trial   = {src_rem, src_quo[DIV_W-1]};
    diff    = trial - {1'b0, src_div};
    nxt_rem = trial[DVS_W-1:0];
    nxt_quo = {src_quo[DIV_W-2:0], 1'b0};
    if (trial >= {1'b0, src_div}) begin
      nxt_rem = diff[DVS_W-1:0];
      nxt_quo = {src_quo[DIV_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      quo   <= '0;
      div_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem   <= nxt_rem;
      quo   <= nxt_quo;
      div_q <= divisor;
      cnt   <= CNT_W'(DIV_W - 1);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      rem <= nxt_rem;
      quo <= nxt_quo;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/depth_to_disparity.sv
// Target depth + left x -> expected disparity and predicted right x.
// Define DEPTH_TO_DISP_ROUND_EN for a round-half-up divide instead of truncation.
module depth_to_disparity
  import parallax_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic [X_W-1:0]     x_ref_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [X_W-1:0]     disparity_out,
  output logic [X_W-1:0]     x_right_out,
  output logic               out_of_view_out,
  output logic               valid_out,
  input  logic               ready_in
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid, once raised, and its data stay put until that transfer happens.

  localparam logic [X_W-1:0] DISP_MAX = '1;

  d2d_state_t state;
  d2d_state_t nxt_state;

  logic [DEPTH_W-1:0] depth_q;
  logic [X_W-1:0]     x_q;
  logic               accept;
  logic               in_special;
  logic               q_special;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [DIV_W-1:0]   dividend;
  logic [DIV_W-1:0]   quotient;
  logic               load_result;

  logic [X_W-1:0]     raw_disp;
  logic               sat;
  logic [X_W-1:0]     res_xr;
  logic               res_oov;

  assign ready_out  = (state == IDLE) && !div_busy;
  assign accept     = valid_in && ready_out;
  assign in_special = (depth_in == '0) || (depth_in == DEPTH_INF);
  assign q_special  = (depth_q == '0) || (depth_q == DEPTH_INF);
  assign div_start  = accept && !in_special;

`ifdef DEPTH_TO_DISP_ROUND_EN
  assign dividend = DIV_W'(PARALLAX_SCALE) + DIV_W'(depth_in >> 1);
`else
  assign dividend = DIV_W'(PARALLAX_SCALE);
`endif

  seq_divider #(
    .DIV_W (DIV_W),
    .DVS_W (DEPTH_W)
  ) u_div (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (depth_in),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      depth_q <= '0;
      x_q     <= '0;
    end else if (accept) begin
      depth_q <= depth_in;
      x_q     <= x_ref_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= nxt_state;
  end

  always_comb begin
    nxt_state   = state;
    load_result = 1'b0;
    case (state)
      IDLE:   if (valid_in && !div_busy) nxt_state = DIVIDE;
      DIVIDE: if (q_special || div_done) begin
        nxt_state   = DONE;
        load_result = 1'b1;
      end
      DONE:   if (ready_in) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Depth 0 is "at the camera": treat as maximal disparity, which also clips x_right.
  always_comb begin
    raw_disp = quotient[X_W-1:0];
    sat      = 1'b0;
    if (depth_q == '0) begin
      raw_disp = DISP_MAX;
      sat      = 1'b1;
    end else if (depth_q == DEPTH_INF) begin
      raw_disp = '0;
    end else if (quotient > DIV_W'(DISP_MAX)) begin
      raw_disp = DISP_MAX;
      sat      = 1'b1;
    end
    res_xr  = x_q - raw_disp;
    res_oov = sat;
    if (raw_disp > x_q) begin
      res_xr  = '0;
      res_oov = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      disparity_out   <= '0;
      x_right_out     <= '0;
      out_of_view_out <= 1'b0;
      valid_out       <= 1'b0;
    end else if (load_result) begin
      disparity_out   <= raw_disp;
      x_right_out     <= res_xr;
      out_of_view_out <= res_oov;
      valid_out       <= 1'b1;
    end else if (state == DONE && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule
